// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver (and the future
// transmitter).
//   - UART_DATA_BITS : data bits per frame
//   - rx_state_e     : receiver FSM state encoding (3 bits)
//   - clks_per_bit() : clock cycles per line bit, truncated
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_bit.sv
// sync_bit: multi-stage flip-flop synchronizer for one asynchronous input.
// Resets to 1 so that an idle-high line (UART, pushbutton, slider) does not
// produce a spurious edge when reset is released.
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset (chain forced to all ones)
//   d_i    asynchronous input
//   q_o    synchronized output, STAGES cycles behind d_i
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver (8N1, LSB first) with a
// valid/ready holding register.
// Optional: define UART_RX_PARITY_EN for 8E1 frames (adds rx_parity_err).
// Ports:
//   clk_ext        system clock
//   rst_ext        asynchronous active-high reset
//   uart_rxd       raw serial line, idle high, asynchronous
//   rx_data        received byte, stable while rx_valid
//   rx_valid       holding register full
//   rx_ready       consumer accepts when rx_valid & rx_ready
//   rx_frame_err   1-cycle pulse: stop bit sampled low
//   rx_overrun     1-cycle pulse: byte completed while holding register full
//   rx_busy        FSM not idle
//   rx_parity_err  (UART_RX_PARITY_EN only) 1-cycle pulse: even parity fails
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_ext,
  input  logic       rst_ext,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  logic rxd_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_ext),
    .rst_i (rst_ext),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  rx_state_e                 state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [7:0]                data_q;
  logic                      valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      byte_ok;

  wire half_done = (cnt_q == CNT_W'(HALF_BIT - 1));
  wire bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  wire accept    = valid_q & rx_ready;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic par_err_q;
  assign byte_ok       = ~par_bad_q;
  assign rx_parity_err = par_err_q;
`else
  assign byte_ok = 1'b1;
`endif

  always_ff @(posedge clk_ext or posedge rst_ext) begin
    if (rst_ext) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (accept) valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) state_q <= ST_START;
        end
        ST_START: begin
          if (half_done) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_q   <= rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rxd_s;
            bit_idx_q          <= bit_idx_q + IDX_W'(1);
            if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            cnt_q     <= '0;
            par_bad_q <= ^{shift_q, rxd_s};
            par_err_q <= ^{shift_q, rxd_s};
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= ST_IDLE;
              if (byte_ok) begin
                // A same-cycle accept frees the register, so the load wins.
                if (valid_q && !rx_ready) begin
                  overrun_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // Hold off through a break until the line returns high.
          if (rxd_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per
// bit, half bit 5). Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;

  localparam int BIT = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int LAT = 2 + 5 + 9 * BIT + 1 + (PAR_ON ? BIT : 0);

  logic       clk_ext = 1'b0;
  logic       rst_ext;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  uart_rx #(
    .CLK_FREQ_HZ (1000000),
    .BAUD_RATE   (100000),
    .SYNC_STAGES (2)
  ) dut (
    .clk_ext      (clk_ext),
    .rst_ext      (rst_ext),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  always #5 clk_ext = ~clk_ext;

  int n_checks = 0;
  int n_fail   = 0;

  // Output monitor, sampled 2 time units after each rising edge.
  int         cyc = 0;
  int         valid_rises = 0, valid_hi = 0, ferr_cnt = 0, ovr_cnt = 0;
  int         busy_cnt = 0, perr_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] cap_data = 8'h00;
  logic       prev_valid = 1'b0;

  always @(posedge clk_ext) begin
    #2;
    cyc++;
    if (rx_valid) valid_hi++;
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      rise_cyc = cyc;
      cap_data = rx_data;
    end
    prev_valid = rx_valid;
    if (rx_frame_err) ferr_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (rx_busy) busy_cnt++;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) perr_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a falling edge; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk_ext);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (BIT) @(negedge clk_ext);
    end
    if (PAR_ON) begin
      uart_rxd = par;
      repeat (BIT) @(negedge clk_ext);
    end
    uart_rxd = stop;
    repeat (BIT) @(negedge clk_ext);
  endtask

  int vr0, vh0, f0, o0, b0, p0, start_cyc;

  initial begin
    rst_ext  = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk_ext);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_frame_err", rx_frame_err, 1'b0);
    chk("reset rx_overrun", rx_overrun, 1'b0);
    chk("reset rx_busy", rx_busy, 1'b0);
    rst_ext = 1'b0;
    repeat (5) @(negedge clk_ext);

    // Clean frame 0xA5 with consumer ready.
    rx_ready = 1'b1;
    vr0 = valid_rises; vh0 = valid_hi; f0 = ferr_cnt; o0 = ovr_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    repeat (3) @(negedge clk_ext);
    chk("a5 valid rises", valid_rises - vr0, 1);
    chk("a5 valid cycles", valid_hi - vh0, 1);
    chk("a5 data", cap_data, 8'hA5);
    chk("a5 latency", rise_cyc - start_cyc, LAT);
    chk("a5 frame_err", ferr_cnt - f0, 0);
    chk("a5 overrun", ovr_cnt - o0, 0);
    chk("a5 busy after", rx_busy, 1'b0);
    chk("a5 valid after", rx_valid, 1'b0);

    // 3-cycle low glitch on idle line.
    vr0 = valid_rises; b0 = busy_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk_ext);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk_ext);
    chk("glitch busy cycles", busy_cnt - b0, 5);
    chk("glitch valid", valid_rises - vr0, 0);
    chk("glitch busy after", rx_busy, 1'b0);

    // 0x3C with a low stop bit, break held 20 more cycles.
    vr0 = valid_rises; f0 = ferr_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (20) @(negedge clk_ext);
    chk("ferr pulse", ferr_cnt - f0, 1);
    chk("ferr no valid", valid_rises - vr0, 0);
    chk("ferr busy in break", rx_busy, 1'b1);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk_ext);
    chk("ferr busy until sync", rx_busy, 1'b1);
    @(negedge clk_ext);
    chk("ferr busy released", rx_busy, 1'b0);

    // Back-to-back 0x11, 0x22 with consumer stalled.
    rx_ready = 1'b0;
    vr0 = valid_rises; o0 = ovr_cnt;
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    repeat (3) @(negedge clk_ext);
    chk("ovr valid held", rx_valid, 1'b1);
    chk("ovr data kept", rx_data, 8'h11);
    chk("ovr pulse", ovr_cnt - o0, 1);
    chk("ovr single load", valid_rises - vr0, 1);
    rx_ready = 1'b1;
    @(negedge clk_ext);
    rx_ready = 1'b0;
    chk("ovr valid cleared", rx_valid, 1'b0);
    chk("ovr data stable", rx_data, 8'h11);

    // Reset during bit 4 of 0xFF.
    rx_ready = 1'b1;
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk_ext);
    uart_rxd = 1'b1;
    repeat (4 * BIT + 5) @(negedge clk_ext);
    chk("rst busy before", rx_busy, 1'b1);
    rst_ext = 1'b1;
    #1;
    chk("rst rx_data", rx_data, 8'h00);
    chk("rst rx_valid", rx_valid, 1'b0);
    chk("rst rx_busy", rx_busy, 1'b0);
    chk("rst rx_frame_err", rx_frame_err, 1'b0);
    chk("rst rx_overrun", rx_overrun, 1'b0);
    @(negedge clk_ext);
    @(negedge clk_ext);
    rst_ext = 1'b0;
    repeat (15) @(negedge clk_ext);
    vr0 = valid_rises; f0 = ferr_cnt;
    send_frame(8'h5A, ^8'h5A, 1'b1);
    repeat (3) @(negedge clk_ext);
    chk("post-rst valid", valid_rises - vr0, 1);
    chk("post-rst data", cap_data, 8'h5A);
    chk("post-rst frame_err", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1.
    vr0 = valid_rises; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (3) @(negedge clk_ext);
    chk("par good valid", valid_rises - vr0, 1);
    chk("par good data", cap_data, 8'h07);
    chk("par good no err", perr_cnt - p0, 0);
    vr0 = valid_rises; p0 = perr_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (3) @(negedge clk_ext);
    chk("par bad pulse", perr_cnt - p0, 1);
    chk("par bad no valid", valid_rises - vr0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
